array_mult_scheduler: RTL and testbench

//  Shares one combinational eight_bit_array_multiplier among NUM_REQ requesters.

---
 rtl/mult_sched_pkg.sv | 13 +
 rtl/eight_bit_array_multiplier.sv | 23 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/array_mult_scheduler.sv | 106 ++++++++++
 tb/tb_array_mult_scheduler.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the multiplier-sharing scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

endpackage

// File: rtl/eight_bit_array_multiplier.sv
// Unsigned 8x8 -> 16 combinational array multiplier (shifted partial-product rows).
module eight_bit_array_multiplier (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] S
);

  logic [15:0] pp [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
      assign pp[gi] = {8'd0, (A & {8{B[gi]}})} << gi;
    end
  endgenerate

  always_comb begin
    S = '0;
    for (int k = 0; k < 8; k++) begin
      S = S + pp[k];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand [N];
  logic [N-1:0]  hit;

  // cand[gi] is the requester index gi positions after ptr.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [IW:0] sum;
      assign sum      = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from the farthest offset down so the nearest hit overrides.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (hit[k]) begin
        grant            = '0;
        grant[cand[k]]   = 1'b1;
        grant_idx        = cand[k];
      end
    end
  end

endmodule

// File: rtl/array_mult_scheduler.sv
// Shares one array multiplier among NUM_REQ requesters with round-robin arbitration
// and a single tagged response port (IDLE -> CALC -> RESP).
module array_mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    busy
);

  sched_state_t      state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [OP_W-1:0]   op_a_reg, op_a_next;
  logic [OP_W-1:0]   op_b_reg, op_b_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
  logic [PROD_W-1:0] rsp_product_reg, rsp_product_next;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [PROD_W-1:0]  product;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  eight_bit_array_multiplier u_mult (
    .A (op_a_reg),
    .B (op_b_reg),
    .S (product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      id_reg          <= '0;
      rsp_id_reg      <= '0;
      rsp_product_reg <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      op_a_reg        <= op_a_next;
      op_b_reg        <= op_b_next;
      id_reg          <= id_next;
      rsp_id_reg      <= rsp_id_next;
      rsp_product_reg <= rsp_product_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    op_a_next        = op_a_reg;
    op_b_next        = op_b_reg;
    id_next          = id_reg;
    rsp_id_next      = rsp_id_reg;
    rsp_product_next = rsp_product_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          op_a_next  = req_a[OP_W*int'(grant_idx) +: OP_W];
          op_b_next  = req_b[OP_W*int'(grant_idx) +: OP_W];
          id_next    = grant_idx;
          state_next = CALC;
        end
      end
      CALC: begin
        rsp_product_next = product;
        rsp_id_next      = id_reg;
        state_next       = RESP;
      end
      RESP: begin
        // Pointer moves only on completion so a stalled consumer cannot skew fairness.
        if (rsp_ready) begin
          rr_ptr_next = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready   = (state_reg == IDLE) ? grant : '0;
  assign rsp_valid   = (state_reg == RESP);
  assign busy        = (state_reg != IDLE);
  assign rsp_id      = rsp_id_reg;
  assign rsp_product = rsp_product_reg;

endmodule

// File: tb/tb_array_mult_scheduler.sv
// Directed self-checking bench for array_mult_scheduler (NUM_REQ=4).
module tb_array_mult_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic        busy;

  int checks = 0;
  int errors = 0;

  array_mult_scheduler #(.NUM_REQ(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 ||
        rsp_id !== 2'd0 || rsp_product !== 16'h0000)
      $display("FAIL reset_values: valid=%b busy=%b ready=%b id=%0d prod=%h required 0 0 0000 0 0000",
               rsp_valid, busy, req_ready, rsp_id, rsp_product);
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 ||
        rsp_id !== 2'd0 || rsp_product !== 16'h0000) errors++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_req: busy=%b ready=%b required 0 0000", busy, req_ready);
    end
    $display("reset: released, idle");
  endtask

  task automatic test_single();
    apply_reset();
    set_ops(0, 8'hFF, 8'hFF);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: req_ready=%b required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_calc: ready=%b valid=%b busy=%b required 0000 0 1", req_ready, rsp_valid, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_product !== 16'hFE01 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL single_rsp: valid=%b prod=%h id=%0d required 1 fe01 0", rsp_valid, rsp_product, rsp_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: valid=%b busy=%b required 0 0", rsp_valid, busy);
    end
    $display("single: id=%0d 0xFF*0xFF prod=%h", rsp_id, rsp_product);
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0]  exp_id    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_prod  [5] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd3};
    int n;
    apply_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'd3);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      #1;
      while (req_ready === 4'b0000 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      checks++;
      if (req_ready !== exp_grant[k]) begin
        errors++;
        $display("FAIL rr_grant%0d: req_ready=%b required %b", k, req_ready, exp_grant[k]);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id[k] || rsp_product !== exp_prod[k]) begin
        errors++;
        $display("FAIL rr_rsp%0d: valid=%b id=%0d prod=%0d required 1 %0d %0d",
                 k, rsp_valid, rsp_id, rsp_product, exp_id[k], exp_prod[k]);
      end
      $display("round_robin: txn %0d id=%0d prod=%0d", k, rsp_id, rsp_product);
      if (k == 4) req_valid = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 8'h11, 8'h01);
    set_ops(2, 8'h12, 8'h34);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: req_ready=%b required 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b1011;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_product !== 16'h03A8 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d prod=%h ready=%b required 1 2 03a8 0000",
                 c, rsp_valid, rsp_id, rsp_product, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release: valid=%b req_ready=%b required 0 1000", rsp_valid, req_ready);
    end
    $display("backpressure: id=2 prod=%h held 5 cycles, next grant=%b", rsp_product, req_ready);
    apply_reset();
  endtask

  task automatic test_edge_operands();
    logic [7:0]  ta [3] = '{8'h00, 8'h80, 8'h01};
    logic [7:0]  tb [3] = '{8'hAB, 8'h02, 8'hFF};
    logic [15:0] tp [3] = '{16'h0000, 16'h0100, 16'h00FF};
    logic [3:0]  tg [3] = '{4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_ops(k + 1, ta[k], tb[k]);
      req_valid = tg[k];
      #1;
      checks++;
      if (req_ready !== tg[k]) begin
        errors++;
        $display("FAIL edge_grant%0d: req_ready=%b required %b", k, req_ready, tg[k]);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_product !== tp[k] || rsp_id !== 2'(k + 1)) begin
        errors++;
        $display("FAIL edge_rsp%0d: valid=%b prod=%h id=%0d required 1 %h %0d",
                 k, rsp_valid, rsp_product, rsp_id, tp[k], k + 1);
      end
      $display("edge: %h*%h prod=%h", ta[k], tb[k], rsp_product);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic seen_valid;
    set_ops(1, 8'h10, 8'h10);
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_state: busy=%b valid=%b required 1 0", busy, rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 ||
        rsp_id !== 2'd0 || rsp_product !== 16'h0000) begin
      errors++;
      $display("FAIL midcalc_async: busy=%b valid=%b ready=%b id=%0d prod=%h required 0 0 0000 0 0000",
               busy, rsp_valid, req_ready, rsp_id, rsp_product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || rsp_product !== 16'h0000) begin
      errors++;
      $display("FAIL midcalc_no_rsp: activity=%b prod=%h required 0 0000", seen_valid, rsp_product);
    end
    $display("reset_mid_calc: transaction discarded");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_edge_operands();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
